// File: rtl/ram_responder.sv
// rtl/ram_responder.sv - byte-masked RAM responder with fixed-latency ready handshake
module ram_responder #(
    parameter int WIDTH      = 128,
    parameter int DEPTH      = 6607,
    parameter int ADDR_WIDTH = 27,
    parameter int LATENCY    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [WIDTH-1:0]      din,
    output logic [WIDTH-1:0]      dout,
    input  logic [WIDTH/8-1:0]    mask,
    input  logic                  re,
    input  logic                  we,
    output logic                  ready
);

    localparam int NB    = WIDTH / 8;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = 4;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [WIDTH-1:0]      din_q, din_d;
    logic [NB-1:0]         mask_q, mask_d;
    logic                  wr_q, wr_d;
    logic [WIDTH-1:0]      dout_q, dout_d;

    logic [WIDTH-1:0]      mem_q [DEPTH];

    logic                  accept;
    logic                  enter_done;
    logic [ADDR_WIDTH-1:0] op_addr;
    logic [WIDTH-1:0]      op_din;
    logic [NB-1:0]         op_mask;
    logic                  op_wr;
    logic                  op_in_range;
    logic [IDX_W-1:0]      op_idx;
    logic [WIDTH-1:0]      rd_word;
    logic                  commit;

    assign accept = (state_q == S_IDLE) && (re || we);

    // With LATENCY=1 the access completes on the accepting edge, so the live
    // inputs are used instead of the not-yet-loaded capture registers.
    assign op_addr = accept ? addr : addr_q;
    assign op_din  = accept ? din  : din_q;
    assign op_mask = accept ? mask : mask_q;
    assign op_wr   = accept ? we   : wr_q;

    assign op_in_range = (op_addr < ADDR_WIDTH'(DEPTH));
    assign op_idx      = op_addr[IDX_W-1:0];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        din_d   = din_q;
        mask_d  = mask_q;
        wr_d    = wr_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    addr_d = addr;
                    din_d  = din;
                    mask_d = mask;
                    wr_d   = we;
                    if (LATENCY == 1) begin
                        state_d = S_DONE;
                        cnt_d   = '0;
                    end else begin
                        state_d = S_BUSY;
                        cnt_d   = CNT_W'(LATENCY - 1);
                    end
                end
            end
            S_BUSY: begin
                // The edge that drains the counter is the edge that enters DONE.
                if (cnt_q <= CNT_W'(1)) begin
                    state_d = S_DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign enter_done = (state_d == S_DONE) && (state_q != S_DONE);
    assign commit     = enter_done && op_wr && op_in_range;

    always_comb begin
        rd_word = '0;
        if (op_in_range) begin
            rd_word = mem_q[op_idx];
        end
    end

    always_comb begin
        dout_d = dout_q;
        if (enter_done && !op_wr) begin
            dout_d = rd_word;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            din_q   <= '0;
            mask_q  <= '0;
            wr_q    <= 1'b0;
            dout_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
            mask_q  <= mask_d;
            wr_q    <= wr_d;
            dout_q  <= dout_d;
        end
    end

    // Storage survives reset; reset only blocks a commit on that edge.
    always_ff @(posedge clk) begin
        if (rst && commit) begin
            for (int b = 0; b < NB; b++) begin
                if (op_mask[b]) begin
                    mem_q[op_idx][8*b +: 8] <= op_din[8*b +: 8];
                end
            end
        end
    end

    assign dout  = dout_q;
    assign ready = (state_q == S_DONE);

endmodule

// File: doc/ram_responder.md
RAM_RESPONDER -- requirements
Module: ram_responder

Interface
REQ-001 Parameter WIDTH, default 128, data word width in bits; multiple of 8.
REQ-002 Parameter DEPTH, default 6607, number of words stored.
REQ-003 Parameter ADDR_WIDTH, default 27, word-address width.
REQ-004 Parameter LATENCY, default 2, cycles from request acceptance to ready; legal range 1..15.
REQ-005 clk  input  1  sole clock; all state changes on rising edge.
REQ-006 rst  input  1  synchronous, active-low reset.
REQ-007 addr  input  ADDR_WIDTH  word address of request.
REQ-008 din  input  WIDTH  write data from initiator.
REQ-009 dout  output  WIDTH  read data to initiator.
REQ-010 mask  input  WIDTH/8  byte write enables; bit i enables din[8i+7:8i].
REQ-011 re  input  1  read request, held high by initiator until ready seen.
REQ-012 we  input  1  write request, held high by initiator until ready seen.
REQ-013 ready  output  1  one-cycle completion pulse for the current request.

Function
REQ-014 The block SHALL be the responder end of the ram handshake: storage array DEPTH x WIDTH plus control FSM with states IDLE, BUSY, DONE.
REQ-015 In IDLE, re or we high at a rising edge SHALL accept the request, capturing addr, din, mask, and operation type into internal registers.
REQ-016 After acceptance the FSM SHALL go to BUSY with a down-counter loaded to LATENCY-1; for LATENCY=1 it SHALL go directly to DONE.
REQ-017 In BUSY the counter SHALL decrement each cycle; at count 0 the FSM SHALL go to DONE on the next edge.
REQ-018 ready SHALL be 1 exactly in the DONE cycle, i.e. cycle N+LATENCY for a request accepted at edge N, and 0 otherwise.
REQ-019 DONE SHALL always return to IDLE after one cycle; re/we still high in the IDLE cycle SHALL be accepted as a new request.
REQ-020 re/we/addr/din/mask changes during BUSY or DONE SHALL be ignored; only captured values are used.
REQ-021 Writes SHALL commit on the edge entering DONE, updating only bytes whose mask bit is 1; mask all-zero SHALL leave the word unchanged.
REQ-022 Reads SHALL load dout on the edge entering DONE with the stored word at the captured address; dout SHALL hold that value until the next read completes.
REQ-023 Write completions SHALL NOT change dout.
REQ-024 re and we both high at acceptance SHALL be treated as a write only.
REQ-025 Captured address >= DEPTH: write SHALL be discarded, read SHALL return all-zero dout; ready SHALL still pulse at normal latency.
REQ-026 A read following a write to the same address SHALL return the post-write, merged word.
REQ-027 Throughput: one request per LATENCY+1 cycles maximum.

Reset
REQ-028 rst low at a rising edge SHALL force state IDLE, counter 0, ready 0, dout all-zero.
REQ-029 Reset SHALL NOT clear storage contents.
REQ-030 Reset asserted while in BUSY SHALL abort the request: pending write not committed, no ready pulse.
REQ-031 re/we high while rst is low SHALL NOT be accepted; first acceptance possible at the first edge with rst high.

Verification
REQ-032 LATENCY=2: write addr 5, din 0x00112233_44556677_8899AABB_CCDDEEFF, mask 0xFFFF, then read addr 5 -> each ready 2 cycles after acceptance; dout = written value.
REQ-033 Write addr 5 mask 0x0001 din all-0x11 over prior word from REQ-032 -> read returns 0x00112233_44556677_8899AABB_CCDDEE11.
REQ-034 Read addr 6607 (out of range) -> ready pulses at latency, dout = 0; write addr 7000 -> no stored word changes.
REQ-035 re and we both high, addr 9, din 0xA..A, mask 0xFFFF -> write performed, dout unchanged; later read addr 9 -> 0xA..A.
REQ-036 rst low in BUSY of write to addr 3 -> no ready pulse, addr 3 keeps previous contents, dout = 0 after reset.
REQ-037 LATENCY=1 with re held high continuously, addr 5 -> ready high every other cycle, dout stable at stored word.
